// File: rtl/series_engine.sv
// Sequential evaluator for S(x) = sum s_k * x^k / k, one term per clock, with early exit when x^k truncates to zero.
// Mode 0 alternates signs (ln(1+x)); mode 1 adds every term (-ln(1-x)).
module series_engine #(
  parameter int WIDTH = 16,
  parameter int TERMS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   x_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH+1:0]   result_o,
  output logic [4:0]         terms_used_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [4:0] LAST_K = 5'(TERMS);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   xr_q, xr_d;
  logic               mr_q, mr_d;
  logic [4:0]         k_q, k_d;
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic [WIDTH+1:0]   result_q, result_d;
  logic [4:0]         terms_q, terms_d;

  logic [7:0]         coef_c;
  logic [WIDTH-1:0]   t_c;
  logic [WIDTH-1:0]   p_next_c;
  logic [WIDTH+1:0]   acc_next_c;
  logic               last_c;

  // Q0.8 approximations of 1/k; k=1 saturates to 0xFF
  always_comb begin
    coef_c = 8'h00;
    case (k_q)
      5'd1:  coef_c = 8'hFF;
      5'd2:  coef_c = 8'h80;
      5'd3:  coef_c = 8'h55;
      5'd4:  coef_c = 8'h40;
      5'd5:  coef_c = 8'h33;
      5'd6:  coef_c = 8'h2A;
      5'd7:  coef_c = 8'h24;
      5'd8:  coef_c = 8'h20;
      5'd9:  coef_c = 8'h1C;
      5'd10: coef_c = 8'h19;
      5'd11: coef_c = 8'h17;
      5'd12: coef_c = 8'h15;
      5'd13: coef_c = 8'h13;
      5'd14: coef_c = 8'h12;
      5'd15: coef_c = 8'h11;
      5'd16: coef_c = 8'h10;
      default: coef_c = 8'h00;
    endcase
  end

  assign t_c      = WIDTH'(({8'h00, p_q} * {{WIDTH{1'b0}}, coef_c}) >> 8);
  assign p_next_c = WIDTH'(({{WIDTH{1'b0}}, p_q} * {{WIDTH{1'b0}}, xr_q}) >> WIDTH);
  assign acc_next_c = (mr_q || k_q[0]) ? acc_q + {2'b00, t_c} : acc_q - {2'b00, t_c};
  assign last_c   = (k_q == LAST_K) || (p_next_c == '0);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    xr_d     = xr_q;
    mr_d     = mr_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    terms_d  = terms_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          xr_d    = x_i;
          mr_d    = mode_i;
          p_d     = x_i;
          k_d     = 5'd1;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_next_c;
        p_d   = p_next_c;
        if (last_c) begin
          result_d = acc_next_c;
          terms_d  = k_q;
          state_d  = S_DONE;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      xr_q     <= '0;
      mr_q     <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      terms_q  <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      xr_q     <= xr_d;
      mr_q     <= mr_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      terms_q  <= terms_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign result_o     = result_q;
  assign terms_used_o = terms_q;

endmodule

// File: doc/series_engine.md
# series_engine

Parametrised sequential evaluator for the reciprocal power series S(x) = Σ s_k·x^k/k, k = 1..N, using the team's 8-bit 1/k coefficient table. It computes one series term per clock and exits early once the power term truncates to zero. It sits beside the add/sub, multiplier and compare datapath, and replaces hand-sequenced counter/register/LUT series evaluation with a single start/busy/done block. Mode 0 gives ln(1+x) (alternating signs); mode 1 gives −ln(1−x) (all positive).

## Interface
- WIDTH, 16: operand width. x is unsigned Q0.WIDTH. Legal range 8..32.
- TERMS, 8: maximum number of series terms N. Legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- mode  input  1  0: alternating signs (+,−,+,…). 1: all terms added. Captured with start.
- x  input  WIDTH  operand. Captured with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH+2  unsigned Q2.WIDTH sum. Held until the next completion.
- terms_used  output  5  number of terms accumulated in the last computation.

## Operation
- Coefficient c_k is 8-bit Q0.8: k=1..16 → FF,80,55,40,33,2A,24,20,1C,19,17,15,13,12,11,10 (hex).
- Internal registers:
  - p, WIDTH bits: power term.
  - k, 5 bits: term index.
  - acc, WIDTH+2 bits.
  - xr, mr: captured x and mode.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: xr←x, mr←mode, p←x, k←1, acc←0; go to RUN.
- IDLE with start=0: hold.
- RUN, each cycle:
  - t = (p·c_k) >> 8, truncated, WIDTH bits.
  - acc ← acc + t if mr=1 or k odd; otherwise acc ← acc − t.
  - p_next = (p·xr) >> WIDTH, truncated; p ← p_next.
  - If k == TERMS or p_next == 0: result ← updated acc, terms_used ← k, go to DONE.
  - Otherwise k ← k+1.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. A start arriving in the DONE cycle is dropped.
- Width guarantees:
  - p and c_k are non-increasing, so t_k is non-increasing.
  - Mode 0: acc stays within [0, t_1] and never wraps.
  - Mode 1: Σ_{k≤16} 1/k < 4, so acc never exceeds WIDTH+2 bits.
  - No saturation logic is needed; the bench asserts both bounds.
- x = 0: t_1 = 0 and p_next = 0, so the block finishes after 1 term with result 0.
- Reset values: FSM=IDLE, busy=0, done=0, result=0, terms_used=0, and all internal registers 0.
- Reset asserted mid-RUN aborts immediately. result and terms_used go to 0; no done pulse follows.

## Timing
- Edge E0 samples start=1 in IDLE. busy rises after E0.
- RUN occupies edges E1..En, where n = terms_used ≤ TERMS.
- result and terms_used update at En. done is high in the cycle after En.
- FSM returns to IDLE at E(n+1); busy and done fall together.
- Latency from start to done is n+1 cycles; worst case TERMS+1.
- Minimum spacing between accepted starts is n+2 edges.
- Throughput is one term per cycle. Multipliers are WIDTH×8 and WIDTH×WIDTH, combinational within one cycle, and not pipelined.

## Test plan
- WIDTH=16, TERMS=8, x=0x8000, mode=1 → terms_used=8, result=0x0B0C8, done pulses 9 cycles after the start edge.
- Same operand, mode=0 → result=0x06738 (ln 1.5 ≈ 0x067CD; the difference is truncation), terms_used=8.
- x=0x0100, mode=0 → p sequence 0x100, 1, 0; terms_used=2, result=0x000FF, done 3 cycles after start. x=0 → terms_used=1, result=0.
- Hold start high through RUN and DONE → exactly one computation; a second computation starts only after a start sampled in IDLE; result is stable between done pulses.
- Assert rst at the 4th RUN cycle of the x=0x8000 case → busy, done, result and terms_used go to 0 at once; no done pulse; a new start after reset gives 0x0B0C8.
- TERMS=16, x=0xFFFF, mode=1 → terms_used=16, no acc overflow, result matches the reference model bit-exactly; repeat a random x sweep in both modes against the model.
